// File: rtl/bnn_rx_loader_pkg.sv
// rtl/bnn_rx_loader_pkg.sv - shared types and constants for the BNN receive loader
package bnn_pkg;

    localparam int BYTE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        RUN
    } loader_state_t;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'b00,
        CMD_LOAD_IMG = 2'b01,
        CMD_LOAD_WGT = 2'b10,
        CMD_RUN      = 2'b11
    } cmd_op_t;

endpackage

// File: rtl/bnn_rx_loader_if.sv
// rtl/bnn_rx_loader_if.sv - receive, buffer write and core start/done signals of the loader
interface bnn_rx_loader_if import bnn_pkg::*; #(
    parameter int ADDR_W = 6
);
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rts;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;
    logic              wr_ready;
    logic              bnn_start;
    logic              bnn_done;

    modport master (
        input  rx_valid, rx_data, wr_ready, bnn_done,
        output rts, wr_en, wr_sel, wr_addr, wr_data, bnn_start
    );

    modport slave (
        output rx_valid, rx_data, wr_ready, bnn_done,
        input  rts, wr_en, wr_sel, wr_addr, wr_data, bnn_start
    );
endinterface

// File: rtl/bnn_rx_loader_rx_hold_reg.sv
// rtl/bnn_rx_loader_rx_hold_reg.sv - one-entry byte holding register with overrun detection
module rx_hold_reg import bnn_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              consume,
    output logic              hold_valid,
    output logic [BYTE_W-1:0] hold_data,
    output logic              capture,
    output logic              overrun
);
    // A byte is taken when the slot is empty or being emptied this same cycle.
    assign capture = rx_valid && (!hold_valid || consume);
    assign overrun = rx_valid && hold_valid && !consume;

    // Slot contents: capture wins over consume so the pipe never bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_data  <= rx_data;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/bnn_rx_loader.sv
// rtl/bnn_rx_loader.sv - frame controller from UART bytes to BNN buffers and inference start
module bnn_rx_loader import bnn_pkg::*; #(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_W      = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_rx_loader_if.master      bus,
    output logic                 busy,
    output logic                 err,
    output logic                 frame_done
);
    localparam logic [BYTE_W-1:0] DEPTH_B  = BYTE_W'(DEPTH);
    localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT_CYC - 1);

    loader_state_t     state_q, state_d;
    logic              hold_valid, capture, overrun;
    logic [BYTE_W-1:0] hold_data;
    cmd_op_t           op;
    logic              consume, do_write, set_err, clr_err, load_cmd, len_ok, finish, tmo_hit;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] cnt_q;
    logic [15:0]       tmo_q;
    logic              sel_q, err_q, done_q, start_run;

    rx_hold_reg u_hold (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (bus.rx_valid),
        .rx_data    (bus.rx_data),
        .consume    (consume),
        .hold_valid (hold_valid),
        .hold_data  (hold_data),
        .capture    (capture),
        .overrun    (overrun)
    );

    assign op      = cmd_op_t'(hold_data[BYTE_W-1 -: 2]);
    assign tmo_hit = (state_q == LEN || state_q == PAYLOAD) && !hold_valid && (tmo_q == TMO_LAST);

    assign bus.rts       = !hold_valid && (state_q != RUN);
    assign bus.wr_en     = (state_q == PAYLOAD) && hold_valid;
    assign bus.wr_data   = (state_q == PAYLOAD) ? hold_data : '0;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_sel    = sel_q;
    assign bus.bnn_start = start_run;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;
    assign frame_done    = done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        consume   = 1'b0;
        do_write  = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        load_cmd  = 1'b0;
        len_ok    = 1'b0;
        finish    = 1'b0;
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_valid) begin
                    consume = 1'b1;
                    case (op)
                        CMD_LOAD_IMG, CMD_LOAD_WGT: begin
                            clr_err  = 1'b1;
                            load_cmd = 1'b1;
                            state_d  = LEN;
                        end
                        CMD_RUN: begin
                            clr_err   = 1'b1;
                            start_run = 1'b1;
                            state_d   = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            LEN: begin
                if (hold_valid) begin
                    consume = 1'b1;
                    if (hold_data == '0 || hold_data > DEPTH_B) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        len_ok  = 1'b1;
                        state_d = PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (hold_valid) begin
                    if (bus.wr_ready) begin
                        consume  = 1'b1;
                        do_write = 1'b1;
                        if (cnt_q == BYTE_W'(1)) begin
                            finish  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.bnn_done) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: error flag, target select, address/count, done pulse and idle timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            sel_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            if (set_err || overrun) err_q <= 1'b1;
            else if (clr_err)       err_q <= 1'b0;

            if (load_cmd) sel_q <= (op == CMD_LOAD_WGT);

            if (len_ok) begin
                cnt_q  <= hold_data;
                addr_q <= '0;
            end else if (do_write) begin
                cnt_q  <= cnt_q - BYTE_W'(1);
                addr_q <= finish ? '0 : addr_q + ADDR_W'(1);
            end else if (tmo_hit) begin
                addr_q <= '0;
            end

            done_q <= finish;

            if (capture || state_d != state_q)
                tmo_q <= '0;
            else if ((state_q == LEN || state_q == PAYLOAD) && !hold_valid)
                tmo_q <= tmo_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_bnn_rx_loader.sv
// tb/tb_bnn_rx_loader.sv - scoreboard bench for the BNN receive loader
module tb_bnn_rx_loader;
    import bnn_pkg::*;

    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err, frame_done;

    bnn_rx_loader_if #(.ADDR_W(ADDR_W)) bus ();

    bnn_rx_loader #(.DEPTH(64), .ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .err        (err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_done = 0;
    int n_start = 0;
    logic [13:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [6:0] b);
        @(posedge clk);
        #1 bus.rx_valid = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rts"}, 32'(bus.rts), 32'd1);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_wr_sel"}, 32'(bus.wr_sel), 32'd0);
        check({tag, "_bnn_start"}, 32'(bus.bnn_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted write and counts pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bnn_start) n_start++;
            if (frame_done) n_done++;
            if (bus.wr_en && bus.wr_ready) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got sel=%0d addr=%0d data=0x%0h expected no write",
                             bus.wr_sel, bus.wr_addr, bus.wr_data);
                end else begin
                    check("write", 32'({bus.wr_sel, bus.wr_addr, bus.wr_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, cyc;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.wr_ready = 1'b1;
        bus.bnn_done = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1 rst = 1'b0;

        // Image load of three bytes.
        d0 = n_done;
        exp_q.push_back({1'b0, 6'd0, 7'h11});
        exp_q.push_back({1'b0, 6'd1, 7'h22});
        exp_q.push_back({1'b0, 6'd2, 7'h33});
        send_byte(7'h20);
        send_byte(7'h03);
        send_byte(7'h11);
        send_byte(7'h22);
        send_byte(7'h33);
        repeat (3) @(negedge clk);
        check("img_done_cnt", 32'(n_done - d0), 32'd1);
        check("img_err", 32'(err), 32'd0);
        check("img_busy", 32'(busy), 32'd0);

        // Weight load with backpressure on the first payload byte.
        bus.wr_ready = 1'b0;
        exp_q.push_back({1'b1, 6'd0, 7'h55});
        exp_q.push_back({1'b1, 6'd1, 7'h66});
        send_byte(7'h40);
        send_byte(7'h02);
        send_byte(7'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_wr_en", 32'(bus.wr_en), 32'd1);
            check("bp_addr", 32'(bus.wr_addr), 32'd0);
            check("bp_data", 32'(bus.wr_data), 32'h55);
            check("bp_rts", 32'(bus.rts), 32'd0);
        end
        @(posedge clk);
        #1 bus.wr_ready = 1'b1;
        send_byte(7'h66);
        repeat (3) @(negedge clk);
        check("bp_busy", 32'(busy), 32'd0);

        // Bad lengths: zero and one beyond the depth.
        w0 = n_wr;
        send_byte(7'h40);
        send_byte(7'h00);
        repeat (2) @(negedge clk);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        send_byte(7'h40);
        send_byte(7'h41);
        repeat (2) @(negedge clk);
        check("len65_err", 32'(err), 32'd1);
        check("len65_busy", 32'(busy), 32'd0);
        check("badlen_writes", 32'(n_wr - w0), 32'd0);

        // Run command clears the error and waits for the core.
        send_byte(7'h60);
        @(negedge clk);
        check("run_start", 32'(bus.bnn_start), 32'd1);
        @(negedge clk);
        check("run_start_off", 32'(bus.bnn_start), 32'd0);
        check("run_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("run_busy", 32'(busy), 32'd1);
            check("run_rts", 32'(bus.rts), 32'd0);
        end
        @(posedge clk);
        #1 bus.bnn_done = 1'b1;
        @(posedge clk);
        #1 bus.bnn_done = 1'b0;
        @(negedge clk);
        check("run_done", 32'(frame_done), 32'd1);
        check("run_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("run_done_off", 32'(frame_done), 32'd0);

        // Overrun: second back-to-back byte dropped while the write is stalled.
        bus.wr_ready = 1'b0;
        exp_q.push_back({1'b0, 6'd0, 7'h11});
        exp_q.push_back({1'b0, 6'd1, 7'h13});
        send_byte(7'h20);
        send_byte(7'h02);
        @(posedge clk);
        #1 bus.rx_valid = 1'b1;
        bus.rx_data = 7'h11;
        @(posedge clk);
        #1 bus.rx_data = 7'h12;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        @(negedge clk);
        check("ovr_err", 32'(err), 32'd1);
        check("ovr_kept", 32'(bus.wr_data), 32'h11);
        @(posedge clk);
        #1 bus.wr_ready = 1'b1;
        send_byte(7'h13);
        repeat (3) @(negedge clk);
        check("ovr_busy", 32'(busy), 32'd0);

        // Timeout after the length byte with no payload.
        send_byte(7'h20);
        send_byte(7'h05);
        check("tmo_err_clr", 32'(err), 32'd0);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                cyc = i;
                break;
            end
        end
        check("tmo_cycles", 32'(cyc), 32'd17);
        check("tmo_err", 32'(err), 32'd1);

        // Reset in the middle of a weight payload, then a fresh frame.
        exp_q.push_back({1'b1, 6'd0, 7'h71});
        send_byte(7'h40);
        send_byte(7'h03);
        send_byte(7'h71);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back({1'b0, 6'd0, 7'h44});
        send_byte(7'h20);
        send_byte(7'h01);
        send_byte(7'h44);
        repeat (4) @(negedge clk);
        check("reload_busy", 32'(busy), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("frame_done_total", 32'(n_done), 32'd5);
        check("bnn_start_total", 32'(n_start), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bnn_rx_loader.md
Name: bnn_rx_loader

Overview:
Frame controller between the UART receiver and the BNN core. It parses 7-bit received bytes into commands and writes payload bytes into the image or weight buffer through a write port with a ready handshake. It starts inference and waits for it to finish. It throttles the sender with rts, and flags framing, overrun and timeout errors.

Parameters:
DEPTH, 64, words per target buffer (image and weight buffers have the same depth); must be ≤ 127
ADDR_W, 6, buffer address width, equal to clog2(DEPTH)
TIMEOUT_CYC, 16'hFFFF, maximum idle clk cycles between bytes inside a frame

Ports:
clk  in  1  single clock domain
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse per received byte
rx_data  in  7  received byte, valid while rx_valid=1
rts  out  1  1 = loader can accept a byte
wr_en  out  1  buffer write request
wr_sel  out  1  0 = image buffer, 1 = weight buffer
wr_addr  out  ADDR_W  buffer write address
wr_data  out  7  buffer write data
wr_ready  in  1  buffer accepts the write this cycle
bnn_start  out  1  one-cycle pulse that starts inference
bnn_done  in  1  inference-complete pulse from the core
busy  out  1  high in any state other than IDLE
err  out  1  sticky error flag, cleared by the next valid command
frame_done  out  1  one-cycle pulse after a LOAD or RUN completes

Behaviour:
- Reset: synchronous, active-high. State=IDLE, hold_valid=0, addr=0, cnt=0, tmo=0.
- Output values in reset: rts=1, wr_en=0, wr_addr=0, wr_data=0, wr_sel=0, bnn_start=0, busy=0, err=0, frame_done=0.
- Hold register (1 entry):
  - rx_valid with hold empty: byte is captured at that edge and hold_valid=1.
  - rx_valid with hold full: byte is dropped and err=1 (overrun). The FSM state is unaffected.
  - Capture and consume in the same cycle: the new byte is captured and hold_valid stays 1.
- rts = !hold_valid && state!=RUN. This is registered-free combinational logic from state and hold_valid.
- Command byte, bits[6:5]:
  - 00 NOP
  - 01 LOAD_IMG
  - 10 LOAD_WGT
  - 11 RUN
  - bits[4:0] are ignored.
- FSM states: IDLE, LEN, PAYLOAD, RUN.
- IDLE: consumes the held byte.
  - NOP: stay in IDLE. err is not cleared.
  - LOAD_*: clear err, latch wr_sel, go to LEN.
  - RUN: clear err, pulse bnn_start in the transition cycle, go to RUN.
- LEN: consumes the held byte as N (1..127).
  - N==0 or N>DEPTH: err=1, go to IDLE.
  - Otherwise: cnt=N, addr=0, go to PAYLOAD.
- PAYLOAD:
  - wr_en = hold_valid.
  - wr_data = held byte, wr_addr = addr.
  - On wr_en && wr_ready: consume the byte, addr+1, cnt-1.
  - When cnt reaches 1 on a write: pulse frame_done next cycle, go to IDLE.
  - While wr_ready=0, wr_en and wr_data hold stable. rts stays 0 because the hold is full.
- RUN:
  - Bytes already held are kept and are not consumed until the FSM returns to IDLE.
  - On bnn_done: frame_done pulse, go to IDLE.
  - bnn_done seen outside RUN is ignored.
- Latency:
  - rx_valid at edge t gives hold_valid at t+1.
  - In PAYLOAD with wr_ready=1, wr_en is high in cycle t+1.
  - rts returns to 1 at t+2.
- Timeout:
  - tmo clears on every byte capture and on every state change.
  - tmo increments in LEN and PAYLOAD while the hold is empty.
  - tmo==TIMEOUT_CYC-1: err=1, go to IDLE, addr=0. Buffer contents already written are left as they are.
- Timeout wait (wr_ready=0 with the hold full) does not count; there is no timeout on wr_ready.
- Address never wraps: N≤DEPTH keeps addr ≤ DEPTH-1.
- Reset mid-frame: everything returns to reset values. A partial buffer load is not rolled back.

Decomposition:
- Package bnn_pkg holds:
  - enum loader_state_t {IDLE, LEN, PAYLOAD, RUN}
  - enum cmd_op_t {CMD_NOP=2'b00, CMD_LOAD_IMG=2'b01, CMD_LOAD_WGT=2'b10, CMD_RUN=2'b11}
  - constant BYTE_W=7
- One sub-module, rx_hold_reg: the 1-entry holding register with overrun detection and a consume input.

Test Plan:
- Image load: bytes 0x20, 0x03, 0x11, 0x22, 0x33 with wr_ready=1 → three writes, wr_sel=0, addr 0/1/2, data 0x11/0x22/0x33; one frame_done pulse; err=0; busy back to 0.
- Backpressure: weight load with N=2, wr_ready=0 for 5 cycles on the first payload byte → wr_en, addr 0 and data stable for 5 cycles; rts=0 throughout; second byte written to addr 1 after release.
- Bad length: 0x40 then 0x00 → err=1, IDLE, no wr_en. Then 0x40, 0x41 (N=65>64) → err=1. A following valid 0x60 clears err.
- Run: 0x60 → bnn_start pulse on the next edge, rts=0 and busy=1 until bnn_done; frame_done one cycle after bnn_done.
- Overrun/timeout: two rx_valid pulses on back-to-back cycles with wr_ready=0 → second byte dropped, err=1. With TIMEOUT_CYC=16, LOAD+len then silence → err=1 and IDLE after 16 cycles.
- Reset mid-PAYLOAD: rst after one of three bytes → all outputs at reset values next cycle; a new frame loads from addr 0.
